// File: rtl/mod_counter.sv
// Modulo up/down counter with load, clear, terminal count and wrap pulses.
// Optional EN prescaler is built only when COUNTER_PRESCALE_EN is defined.
`timescale 1ns/1ps
module mod_counter #(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LD,
  input  logic             UP,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             OV,
  output logic             UF,
  output logic             TC
);

  localparam logic [WIDTH:0] L_MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] L_MAX = L_MOD - (WIDTH+1)'(1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS out of range");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_counter: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] r_counter;
  logic             r_ov;
  logic             r_uf;
  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_ld_sat;
  logic [WIDTH-1:0] w_up_next;
  logic [WIDTH-1:0] w_dn_next;

  // Compare in WIDTH+1 bits so MODULUS == 2**WIDTH does not truncate.
  assign w_at_max  = ({1'b0, r_counter} == L_MAX);
  assign w_at_zero = (r_counter == '0);
  assign w_ld_sat  = ({1'b0, load_val} < L_MOD) ? load_val : L_MAX[WIDTH-1:0];
  assign w_up_next = w_at_max  ? '0 : r_counter + WIDTH'(1);
  assign w_dn_next = w_at_zero ? L_MAX[WIDTH-1:0] : r_counter - WIDTH'(1);

`ifdef COUNTER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] r_ps;

  assign w_step = EN && (r_ps == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_ps <= '0;
    end else if (CLR || LD) begin
      r_ps <= '0;
    end else if (EN) begin
      r_ps <= w_step ? '0 : r_ps + PS_W'(1);
    end
  end
`else
  assign w_step = EN;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_counter <= '0;
      r_ov      <= 1'b0;
      r_uf      <= 1'b0;
    end else begin
      r_ov <= 1'b0;
      r_uf <= 1'b0;
      if (CLR) begin
        r_counter <= '0;
      end else if (LD) begin
        r_counter <= w_ld_sat;
      end else if (w_step) begin
        if (UP) begin
          r_counter <= w_up_next;
          r_ov      <= w_at_max;
        end else begin
          r_counter <= w_dn_next;
          r_uf      <= w_at_zero;
        end
      end
    end
  end

  assign counter = r_counter;
  assign OV      = r_ov;
  assign UF      = r_uf;
  assign TC      = UP ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: four instances share one stimulus bus.
// d0: W8/M256, d1: W4/M10, d2: W4/M16, d3: W4/M10/PRESCALE=3.
`timescale 1ns/1ps
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       Reset, EN, CLR, LD, UP;
  logic [7:0] load_val;

  logic [7:0] cnt0;
  logic [3:0] cnt1, cnt2, cnt3;
  logic       ov0, uf0, tc0, ov1, uf1, tc1, ov2, uf2, tc2, ov3, uf3, tc3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) d0 (
    .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LD(LD), .UP(UP),
    .load_val(load_val), .counter(cnt0), .OV(ov0), .UF(uf0), .TC(tc0));
  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) d1 (
    .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LD(LD), .UP(UP),
    .load_val(load_val[3:0]), .counter(cnt1), .OV(ov1), .UF(uf1), .TC(tc1));
  mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) d2 (
    .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LD(LD), .UP(UP),
    .load_val(load_val[3:0]), .counter(cnt2), .OV(ov2), .UF(uf2), .TC(tc2));
  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) d3 (
    .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LD(LD), .UP(UP),
    .load_val(load_val[3:0]), .counter(cnt3), .OV(ov3), .UF(uf3), .TC(tc3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; EN = 1'b1; UP = 1'b1; CLR = 1'b0; LD = 1'b0; load_val = 8'd0;
    #1 Reset = 1'b1;
    #13;  // t=14: one edge (t=5) has counted
    n_tests++;
    if (cnt0 !== 8'd1) begin n_fail++; $display("FAIL reset_precount: counter=%0d expected 1", cnt0); end
    Reset = 1'b0;
    #0.5;
    n_tests++;
    if (cnt0 !== 8'd0 || ov0 !== 1'b0 || uf0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: counter=%0d OV=%b UF=%b expected 0/0/0", cnt0, ov0, uf0);
    end
    $display("[TB] reset: counter=%0d OV=%b UF=%b", cnt0, ov0, uf0);
    EN = 1'b0;
    @(posedge clk);
    #1 Reset = 1'b1;
  endtask

  task automatic test_up_wrap();
    int exp_c;
    CLR = 1'b1; EN = 1'b0;
    tick();
    CLR = 1'b0; UP = 1'b1; EN = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_c = i % 10;
      n_tests++;
      if (cnt1 !== 4'(exp_c) || ov1 !== (i == 10) || uf1 !== 1'b0 || tc1 !== (exp_c == 9)) begin
        n_fail++;
        $display("FAIL up_wrap step %0d: counter=%0d OV=%b UF=%b TC=%b expected %0d/%b/0/%b",
                 i, cnt1, ov1, uf1, tc1, exp_c, (i == 10), (exp_c == 9));
      end
      $display("[TB] up_wrap: counter=%0d OV=%b TC=%b", cnt1, ov1, tc1);
    end
    EN = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_seq [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    LD = 1'b1; load_val = 8'd2; UP = 1'b0; EN = 1'b0;
    tick();
    n_tests++;
    if (cnt1 !== 4'd2 || tc1 !== 1'b0) begin n_fail++; $display("FAIL down_load: counter=%0d TC=%b expected 2/0", cnt1, tc1); end
    LD = 1'b0; EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (cnt1 !== exp_seq[i] || uf1 !== (i == 2) || ov1 !== 1'b0 || tc1 !== (exp_seq[i] == 4'd0)) begin
        n_fail++;
        $display("FAIL down_wrap step %0d: counter=%0d UF=%b OV=%b TC=%b expected %0d/%b/0/%b",
                 i, cnt1, uf1, ov1, tc1, exp_seq[i], (i == 2), (exp_seq[i] == 4'd0));
      end
      $display("[TB] down_wrap: counter=%0d UF=%b TC=%b", cnt1, uf1, tc1);
    end
    EN = 1'b0;
  endtask

  task automatic test_priority();
    UP = 1'b1; LD = 1'b1; load_val = 8'd5; EN = 1'b0;
    tick();
    n_tests++;
    if (cnt1 !== 4'd5) begin n_fail++; $display("FAIL prio_preload: counter=%0d expected 5", cnt1); end
    CLR = 1'b1; LD = 1'b1; EN = 1'b1; load_val = 8'd7;
    tick();
    n_tests++;
    if (cnt1 !== 4'd0) begin n_fail++; $display("FAIL prio_clr: counter=%0d expected 0", cnt1); end
    CLR = 1'b0;
    tick();
    n_tests++;
    if (cnt1 !== 4'd7 || ov1 !== 1'b0) begin n_fail++; $display("FAIL prio_ld_over_en: counter=%0d OV=%b expected 7/0", cnt1, ov1); end
    load_val = 8'd12; EN = 1'b0;
    tick();
    n_tests++;
    if (cnt1 !== 4'd9) begin n_fail++; $display("FAIL prio_ld_saturate: counter=%0d expected 9", cnt1); end
    n_tests++;
    if (cnt0 !== 8'd12) begin n_fail++; $display("FAIL prio_ld_wide: counter=%0d expected 12", cnt0); end
    $display("[TB] priority: d1 counter=%0d d0 counter=%0d", cnt1, cnt0);
    LD = 1'b0;
  endtask

  task automatic test_full_range_hold();
    LD = 1'b1; load_val = 8'd14; UP = 1'b1; EN = 1'b0;
    tick();
    LD = 1'b0; EN = 1'b1;
    tick();
    n_tests++;
    if (cnt2 !== 4'd15 || tc2 !== 1'b1 || ov2 !== 1'b0) begin
      n_fail++; $display("FAIL full_15: counter=%0d TC=%b OV=%b expected 15/1/0", cnt2, tc2, ov2);
    end
    tick();
    n_tests++;
    if (cnt2 !== 4'd0 || ov2 !== 1'b1 || uf2 !== 1'b0) begin
      n_fail++; $display("FAIL full_rollover: counter=%0d OV=%b UF=%b expected 0/1/0", cnt2, ov2, uf2);
    end
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (cnt2 !== 4'd0 || ov2 !== 1'b0) begin
        n_fail++; $display("FAIL hold %0d: counter=%0d OV=%b expected 0/0", i, cnt2, ov2);
      end
      $display("[TB] hold: counter=%0d OV=%b", cnt2, ov2);
    end
    EN = 1'b1;
    tick(); tick(); tick();
    n_tests++;
    if (cnt2 !== 4'd3) begin n_fail++; $display("FAIL count_to_3: counter=%0d expected 3", cnt2); end
    EN = 1'b0; UP = 1'b0;
    #1;
    n_tests++;
    if (tc2 !== 1'b0) begin n_fail++; $display("FAIL tc_follows_up: TC=%b expected 0", tc2); end
    EN = 1'b1;
    tick();
    n_tests++;
    if (cnt2 !== 4'd2 || uf2 !== 1'b0) begin n_fail++; $display("FAIL dir_flip: counter=%0d UF=%b expected 2/0", cnt2, uf2); end
    LD = 1'b1; load_val = 8'd0; EN = 1'b0;
    tick();
    n_tests++;
    if (tc2 !== 1'b1) begin n_fail++; $display("FAIL tc_zero_down: TC=%b expected 1", tc2); end
    LD = 1'b0; EN = 1'b1;
    tick();
    n_tests++;
    if (cnt2 !== 4'd15 || uf2 !== 1'b1 || ov2 !== 1'b0) begin
      n_fail++; $display("FAIL full_underflow: counter=%0d UF=%b OV=%b expected 15/1/0", cnt2, uf2, ov2);
    end
    $display("[TB] full_range: counter=%0d UF=%b", cnt2, uf2);
    EN = 1'b0;
  endtask

  task automatic test_prescale();
`ifdef COUNTER_PRESCALE_EN
    logic [3:0] exp_run [7] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
    logic [3:0] exp_ld  [3] = '{4'd5, 4'd5, 4'd6};
`else
    logic [3:0] exp_run [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [3:0] exp_ld  [3] = '{4'd6, 4'd7, 4'd8};
`endif
    CLR = 1'b1; EN = 1'b0;
    tick();
    CLR = 1'b0; UP = 1'b1; EN = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_tests++;
      if (cnt3 !== exp_run[i]) begin n_fail++; $display("FAIL prescale_run %0d: counter=%0d expected %0d", i, cnt3, exp_run[i]); end
      $display("[TB] prescale: counter=%0d", cnt3);
    end
    LD = 1'b1; load_val = 8'd5;
    tick();
    n_tests++;
    if (cnt3 !== 4'd5) begin n_fail++; $display("FAIL prescale_load: counter=%0d expected 5", cnt3); end
    LD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (cnt3 !== exp_ld[i]) begin n_fail++; $display("FAIL prescale_after_ld %0d: counter=%0d expected %0d", i, cnt3, exp_ld[i]); end
      $display("[TB] prescale_after_ld: counter=%0d", cnt3);
    end
    EN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_priority();
    test_full_range_hold();
    test_prescale();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
